// File: rtl/sliding_window_ctrl_if.sv
// Bus bundle between the frame sequencer and its neighbours: feature-map RAM
// read port, 3x3 window unit pixel feed, and the legal-window handshake
// towards the convolution MAC array.
interface sliding_window_ctrl_if #(
   parameter int ADDR_W = 15
);
   logic                mem_rd_en;
   logic [ADDR_W-1:0]   mem_addr;
   logic signed [7:0]   mem_rd_data;
   logic                win_rst;
   logic                win_en;
   logic signed [7:0]   win_pixel;
   logic                out_valid;
   logic                out_ready;
   logic [13:0]         out_row;
   logic [13:0]         out_col;

   modport master (
      output mem_rd_en, mem_addr,
      input  mem_rd_data,
      output win_rst, win_en, win_pixel,
      output out_valid, out_row, out_col,
      input  out_ready
   );

   modport slave (
      input  mem_rd_en, mem_addr,
      output mem_rd_data,
      input  win_rst, win_en, win_pixel,
      input  out_valid, out_row, out_col,
      output out_ready
   );
endinterface

// File: rtl/sliding_window_ctrl.sv
// Frame sequencer for the 3x3 sliding-window unit. Clears the unit, streams
// one feature map from RAM through a 2-entry pixel FIFO, flushes the last
// window, and presents only legal (non row-wrapped) windows downstream.
// Optional feature macro: SW_CTRL_STRIDE_EN (honour STRIDE via phase counters).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | wait for start
// S_CLR    | window unit reset for one cycle, counters cleared
// S_STREAM | issue reads base+n, feed FIFO head to window unit
// S_FLUSH  | one extra win_en with pixel 0 to expose the final window
// S_DRAIN  | wait for the final accept, then pulse done
module sliding_window_ctrl #(
   parameter int IMG_WIDTH  = 130,
   parameter int IMG_HEIGHT = 130,
   parameter int ADDR_W     = 15,
   parameter int STRIDE     = 1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_base_addr,
   output logic              o_busy,
   output logic              o_done,
   sliding_window_ctrl_if.master bus
);

   localparam int N     = IMG_WIDTH * IMG_HEIGHT;
   localparam int CNT_W = $clog2(N + 1);

   typedef enum logic [2:0] {S_IDLE, S_CLR, S_STREAM, S_FLUSH, S_DRAIN} state_t;

   state_t             r_state, w_next;
   logic [CNT_W-1:0]   r_rd_cnt;
   logic               r_inflight;
   logic signed [7:0]  r_fifo [2];
   logic               r_wp, r_rp;
   logic [1:0]         r_occ;
   logic [ADDR_W-1:0]  r_base;
   logic               r_have;
   logic [13:0]        r_row, r_col;
   logic               r_ov;
   logic [13:0]        r_orow, r_ocol;
   logic               r_done;

   logic               w_can_pop, w_win_en, w_pop, w_rd_en, w_stream_end;
   logic               w_done_set, w_start_ok, w_legal, w_phase_ok;
   logic [2:0]         w_level;

`ifdef SW_CTRL_STRIDE_EN
   logic [1:0]         r_rph, r_cph;
   assign w_phase_ok = (r_rph == 2'd0) && (r_cph == 2'd0);
`else
   logic               w_unused_stride;
   assign w_unused_stride = (STRIDE != 0);
   assign w_phase_ok      = 1'b1;
`endif

   assign w_start_ok = i_start && !r_done;
   assign w_can_pop  = !r_ov || bus.out_ready;
   // r_row/r_col hold the position of the previously fed pixel, which is the
   // bottom-right of the window the unit will show after this win_en.
   assign w_legal    = r_have && (r_row >= 14'd2) && (r_col >= 14'd2) && w_phase_ok;

   // State register
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   // Next state, pixel strobe, read strobe
   always_comb begin
      w_next       = r_state;
      w_win_en     = 1'b0;
      w_pop        = 1'b0;
      w_rd_en      = 1'b0;
      w_stream_end = 1'b0;
      w_done_set   = 1'b0;
      // The pop in this cycle frees a slot, so a read may be issued alongside
      // it; this keeps 1 pixel/cycle while never holding more than 2 entries.
      w_level      = 3'(r_occ) + 3'(r_inflight) - 3'(w_pop);
      case (r_state)
         S_IDLE: begin
            if (w_start_ok) w_next = S_CLR;
         end
         S_CLR: begin
            w_next = S_STREAM;
         end
         S_STREAM: begin
            w_win_en     = (r_occ != 2'd0) && w_can_pop;
            w_pop        = w_win_en;
            w_level      = 3'(r_occ) + 3'(r_inflight) - 3'(w_pop);
            w_rd_en      = (r_rd_cnt != CNT_W'(N)) && (w_level < 3'd2);
            w_stream_end = (r_rd_cnt == CNT_W'(N)) && !r_inflight &&
                           ((r_occ == 2'd0) || ((r_occ == 2'd1) && w_pop));
            if (w_stream_end) w_next = S_FLUSH;
         end
         S_FLUSH: begin
            w_win_en = w_can_pop;
            if (w_win_en) w_next = S_DRAIN;
         end
         S_DRAIN: begin
            if (w_can_pop) begin
               w_done_set = 1'b1;
               w_next     = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Read counter, in-flight tracking, FIFO pointers and base latch
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_rd_cnt   <= '0;
         r_inflight <= 1'b0;
         r_wp       <= 1'b0;
         r_rp       <= 1'b0;
         r_occ      <= 2'd0;
         r_base     <= '0;
      end else begin
         r_inflight <= w_rd_en;
         if ((r_state == S_IDLE) && w_start_ok) r_base <= i_base_addr;
         if (r_state == S_CLR) begin
            r_rd_cnt <= '0;
            r_wp     <= 1'b0;
            r_rp     <= 1'b0;
            r_occ    <= 2'd0;
         end else begin
            if (w_rd_en)    r_rd_cnt <= r_rd_cnt + 1'b1;
            if (r_inflight) r_wp     <= ~r_wp;
            if (w_pop)      r_rp     <= ~r_rp;
            r_occ <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
         end
      end
   end

   // FIFO storage; read data is captured the cycle after its strobe
   always_ff @(posedge i_clk) begin
      if (r_inflight) r_fifo[r_wp] <= bus.mem_rd_data;
   end

   // Position of the last fed pixel (and stride phases) for window tagging
   always_ff @(posedge i_clk) begin
      if (!i_rst_n || (r_state == S_CLR)) begin
         r_have <= 1'b0;
         r_row  <= 14'd0;
         r_col  <= 14'd0;
`ifdef SW_CTRL_STRIDE_EN
         r_rph  <= 2'd0;
         r_cph  <= 2'd0;
`endif
      end else if (w_win_en) begin
         if (!r_have) begin
            r_have <= 1'b1;
            r_row  <= 14'd0;
            r_col  <= 14'd0;
         end else if (r_col == 14'(IMG_WIDTH - 1)) begin
            r_col <= 14'd0;
            r_row <= r_row + 14'd1;
`ifdef SW_CTRL_STRIDE_EN
            if ((r_row + 14'd1) == 14'd2)      r_rph <= 2'd0;
            else if (r_rph == 2'(STRIDE - 1))  r_rph <= 2'd0;
            else                               r_rph <= r_rph + 2'd1;
`endif
         end else begin
            r_col <= r_col + 14'd1;
`ifdef SW_CTRL_STRIDE_EN
            if ((r_col + 14'd1) == 14'd2)      r_cph <= 2'd0;
            else if (r_cph == 2'(STRIDE - 1))  r_cph <= 2'd0;
            else                               r_cph <= r_cph + 2'd1;
`endif
         end
      end
   end

   // Downstream valid, coordinates and done pulse
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_ov   <= 1'b0;
         r_orow <= 14'd0;
         r_ocol <= 14'd0;
         r_done <= 1'b0;
      end else begin
         r_done <= w_done_set;
         if (r_state == S_CLR) begin
            r_ov <= 1'b0;
         end else if (w_win_en && w_legal) begin
            r_ov   <= 1'b1;
            r_orow <= r_row - 14'd2;
            r_ocol <= r_col - 14'd2;
         end else if (bus.out_ready) begin
            r_ov <= 1'b0;
         end
      end
   end

   assign bus.mem_rd_en = w_rd_en;
   assign bus.mem_addr  = r_base + ADDR_W'(r_rd_cnt);
   assign bus.win_rst   = !i_rst_n || (r_state == S_CLR);
   assign bus.win_en    = w_win_en;
   assign bus.win_pixel = (r_state == S_FLUSH) ? 8'sd0 : r_fifo[r_rp];
   assign bus.out_valid = r_ov;
   assign bus.out_row   = r_orow;
   assign bus.out_col   = r_ocol;
   assign o_busy        = (r_state != S_IDLE);
   assign o_done        = r_done;

endmodule

// File: tb/tb_sliding_window_ctrl.sv
// Bench for sliding_window_ctrl: a 5x4 frame instance with a window-unit
// model, and a 7x7 STRIDE=2 instance for window selection.
module tb_sliding_window_ctrl;

   localparam int W_A = 5, H_A = 4;
   localparam int W_B = 7, H_B = 7;
`ifdef SW_CTRL_STRIDE_EN
   localparam int SB = 2;
   localparam int EXP_B = ((H_B - 3) / 2 + 1) * ((W_B - 3) / 2 + 1);
`else
   localparam int SB = 1;
   localparam int EXP_B = (H_B - 2) * (W_B - 2);
`endif

   typedef struct {int row; int col;} win_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_a, start_b;
   logic [14:0] base_a, base_b;
   logic        busy_a, done_a, busy_b, done_b;
   int          n_checks, n_errors;
   win_t        q_a[$];
   win_t        q_b[$];

   sliding_window_ctrl_if #(.ADDR_W(15)) bus_a ();
   sliding_window_ctrl_if #(.ADDR_W(15)) bus_b ();

   always #5 clk = ~clk;

   sliding_window_ctrl #(.IMG_WIDTH(W_A), .IMG_HEIGHT(H_A), .ADDR_W(15), .STRIDE(1)) dut_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start_a), .i_base_addr(base_a),
      .o_busy(busy_a), .o_done(done_a), .bus(bus_a));

   sliding_window_ctrl #(.IMG_WIDTH(W_B), .IMG_HEIGHT(H_B), .ADDR_W(15), .STRIDE(2)) dut_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b), .i_base_addr(base_b),
      .o_busy(busy_b), .o_done(done_b), .bus(bus_b));

   // RAM models: RAM[i] = i, one-cycle read latency
   always @(posedge clk) begin
      bus_a.mem_rd_data <= bus_a.mem_rd_en ? $signed(bus_a.mem_addr[7:0]) : 8'sh55;
      bus_b.mem_rd_data <= bus_b.mem_rd_en ? $signed(bus_b.mem_addr[7:0]) : 8'sh55;
   end

   // One frame on dut_a; mode 0 = ready high, mode 1 = ready 1-0-0-1 pattern
   task automatic run_a(input logic [14:0] base, input int mode, input bit poke, input bit tim,
                        output int n_win, output int n_en, output int n_done, output int n_rst);
      logic signed [7:0] rx [64];
      logic signed [7:0] ev;
      int  cnt, first_rd, first_en, done_cyc, br;
      bit  ok;
      win_t w;
      for (int r = 0; r <= H_A - 3; r++)
         for (int c = 0; c <= W_A - 3; c++) begin
            w.row = r; w.col = c; q_a.push_back(w);
         end
      n_win = 0; n_en = 0; n_done = 0; n_rst = 0;
      cnt = 0; first_rd = -1; first_en = -1; done_cyc = -1;
      @(negedge clk);
      start_a = 1'b1; base_a = base; bus_a.out_ready = 1'b1;
      @(negedge clk);
      start_a = 1'b0; base_a = 15'd100;
      for (int cyc = 1; cyc <= 600; cyc++) begin
         if (cyc > 1) @(negedge clk);
         bus_a.out_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
         if (poke) begin
            start_a = (cyc == 10);
            base_a  = (cyc == 10) ? 15'd40 : 15'd100;
         end
         if (done_cyc > 0 && cyc == done_cyc + 1) start_a = 1'b0;
         #1;
         if (bus_a.win_rst) n_rst++;
         if (tim && cyc == 1) begin
            n_checks++;
            if (busy_a !== 1'b1 || bus_a.win_rst !== 1'b1) begin
               n_errors++;
               $display("FAIL clr_cycle busy=%b win_rst=%b required 1 1", busy_a, bus_a.win_rst);
            end
         end
         if (bus_a.mem_rd_en && first_rd < 0) first_rd = cyc;
         if (bus_a.out_valid) begin
            n_checks++;
            if (q_a.size() == 0) begin
               n_errors++;
               $display("FAIL extra_window row=%0d col=%0d", bus_a.out_row, bus_a.out_col);
            end else begin
               if (bus_a.out_row !== 14'(q_a[0].row) || bus_a.out_col !== 14'(q_a[0].col)) begin
                  n_errors++;
                  $display("FAIL window_coord got (%0d,%0d) required (%0d,%0d)",
                           bus_a.out_row, bus_a.out_col, q_a[0].row, q_a[0].col);
               end
               if (bus_a.out_ready) begin
                  w  = q_a.pop_front();
                  br = (w.row + 2) * W_A + w.col + 2;
                  n_checks++;
                  if (cnt - 2 != br) begin
                     n_errors++;
                     $display("FAIL window_align bottom_right=%0d required %0d", cnt - 2, br);
                  end
                  ok = 1'b1;
                  for (int i = 0; i < 3; i++)
                     for (int j = 0; j < 3; j++) begin
                        ev = 8'(int'(base) + (w.row + j) * W_A + w.col + i);
                        if (rx[(w.row + j) * W_A + w.col + i] !== ev) ok = 1'b0;
                     end
                  n_checks++;
                  if (!ok) begin
                     n_errors++;
                     $display("FAIL window_data at (%0d,%0d) base %0d top_left=%0d", w.row, w.col,
                              base, rx[w.row * W_A + w.col]);
                  end
                  n_win++;
               end else begin
                  n_checks++;
                  if (bus_a.win_en !== 1'b0) begin
                     n_errors++;
                     $display("FAIL stall_win_en got %b required 0", bus_a.win_en);
                  end
               end
            end
         end
         if (bus_a.win_en) begin
            if (first_en < 0) first_en = cyc;
            if (cnt < 64) rx[cnt] = bus_a.win_pixel;
            cnt++;
            n_en++;
         end
         if (done_a) begin
            n_done++;
            n_checks++;
            if (busy_a !== 1'b0) begin
               n_errors++;
               $display("FAIL busy_on_done got %b required 0", busy_a);
            end
            if (n_done == 1) begin
               done_cyc = cyc;
               start_a  = 1'b1;
               base_a   = 15'd60;
            end
         end
         if (done_cyc > 0 && cyc == done_cyc + 1) begin
            n_checks++;
            if (busy_a !== 1'b0) begin
               n_errors++;
               $display("FAIL start_on_done_ignored busy=%b required 0", busy_a);
            end
         end
         if (done_cyc > 0 && cyc == done_cyc + 3) break;
      end
      start_a = 1'b0;
      n_checks++;
      if (done_cyc < 0) begin
         n_errors++;
         $display("FAIL frame_timeout done not seen within 600 cycles");
      end
      if (tim) begin
         n_checks++;
         if (first_rd != 2 || first_en != 4) begin
            n_errors++;
            $display("FAIL start_latency rd=%0d en=%0d required 2 4", first_rd, first_en);
         end
      end
      n_checks++;
      if (cnt > W_A * H_A && rx[W_A * H_A] !== 8'sd0) begin
         n_errors++;
         $display("FAIL flush_pixel got %0d required 0", rx[W_A * H_A]);
      end
      n_checks++;
      if (q_a.size() != 0) begin
         n_errors++;
         $display("FAIL missing_windows %0d left required 0", q_a.size());
      end
      q_a.delete();
   endtask

   task automatic check_frame(input string tag, input int nw, input int ne, input int nd, input int nr);
      n_checks++;
      if (nw != 6 || ne != W_A * H_A + 1 || nd != 1 || nr != 1) begin
         n_errors++;
         $display("FAIL %s_counts win=%0d en=%0d done=%0d win_rst=%0d required 6 21 1 1",
                  tag, nw, ne, nd, nr);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      n_checks++;
      if (busy_a !== 1'b0 || done_a !== 1'b0 || bus_a.mem_rd_en !== 1'b0 || bus_a.mem_addr !== 15'd0) begin
         n_errors++;
         $display("FAIL reset_ctrl busy=%b done=%b rd=%b addr=%0d required 0 0 0 0",
                  busy_a, done_a, bus_a.mem_rd_en, bus_a.mem_addr);
      end
      n_checks++;
      if (bus_a.win_rst !== 1'b1 || bus_a.win_en !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_win win_rst=%b win_en=%b required 1 0", bus_a.win_rst, bus_a.win_en);
      end
      n_checks++;
      if (bus_a.out_valid !== 1'b0 || bus_a.out_row !== 14'd0 || bus_a.out_col !== 14'd0) begin
         n_errors++;
         $display("FAIL reset_out valid=%b row=%0d col=%0d required 0 0 0",
                  bus_a.out_valid, bus_a.out_row, bus_a.out_col);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int nw, ne, nd, nr;
      run_a(15'd0, 0, 1'b0, 1'b1, nw, ne, nd, nr);
      check_frame("basic", nw, ne, nd, nr);
   endtask

   task automatic test_backpressure();
      int nw, ne, nd, nr;
      run_a(15'd0, 1, 1'b0, 1'b0, nw, ne, nd, nr);
      check_frame("backpressure", nw, ne, nd, nr);
   endtask

   task automatic test_back_to_back();
      int nw, ne, nd, nr;
      run_a(15'd0, 0, 1'b0, 1'b0, nw, ne, nd, nr);
      check_frame("b2b_first", nw, ne, nd, nr);
      run_a(15'd20, 0, 1'b0, 1'b0, nw, ne, nd, nr);
      check_frame("b2b_second", nw, ne, nd, nr);
   endtask

   task automatic test_busy_start();
      int nw, ne, nd, nr;
      run_a(15'd0, 1, 1'b1, 1'b0, nw, ne, nd, nr);
      check_frame("busy_start", nw, ne, nd, nr);
   endtask

   task automatic test_reset_mid();
      int nd, nw, ne, nr;
      bus_a.out_ready = 1'b1;
      @(negedge clk);
      start_a = 1'b1; base_a = 15'd0;
      @(negedge clk);
      start_a = 1'b0;
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      #1;
      n_checks++;
      if (busy_a !== 1'b0 || done_a !== 1'b0 || bus_a.mem_rd_en !== 1'b0 || bus_a.mem_addr !== 15'd0 ||
          bus_a.win_rst !== 1'b1 || bus_a.win_en !== 1'b0 || bus_a.out_valid !== 1'b0 ||
          bus_a.out_row !== 14'd0 || bus_a.out_col !== 14'd0) begin
         n_errors++;
         $display("FAIL midreset_values busy=%b done=%b rd=%b addr=%0d wrst=%b wen=%b ov=%b row=%0d col=%0d",
                  busy_a, done_a, bus_a.mem_rd_en, bus_a.mem_addr, bus_a.win_rst, bus_a.win_en,
                  bus_a.out_valid, bus_a.out_row, bus_a.out_col);
      end
      rst_n = 1'b1;
      nd = 0;
      repeat (30) begin
         @(negedge clk); #1;
         if (done_a) nd++;
      end
      n_checks++;
      if (nd != 0) begin
         n_errors++;
         $display("FAIL midreset_done got %0d pulses required 0", nd);
      end
      run_a(15'd0, 0, 1'b0, 1'b0, nw, ne, nd, nr);
      check_frame("after_reset", nw, ne, nd, nr);
   endtask

   task automatic test_stride();
      int   nw;
      bit   seen;
      win_t w;
      for (int r = 0; r <= H_B - 3; r += SB)
         for (int c = 0; c <= W_B - 3; c += SB) begin
            w.row = r; w.col = c; q_b.push_back(w);
         end
      nw = 0; seen = 1'b0;
      bus_b.out_ready = 1'b1;
      @(negedge clk);
      start_b = 1'b1; base_b = 15'd0;
      @(negedge clk);
      start_b = 1'b0;
      for (int cyc = 0; cyc < 400 && !seen; cyc++) begin
         @(negedge clk); #1;
         if (bus_b.out_valid) begin
            nw++;
            n_checks++;
            if (q_b.size() == 0) begin
               n_errors++;
               $display("FAIL stride_extra row=%0d col=%0d", bus_b.out_row, bus_b.out_col);
            end else begin
               w = q_b.pop_front();
               if (bus_b.out_row !== 14'(w.row) || bus_b.out_col !== 14'(w.col)) begin
                  n_errors++;
                  $display("FAIL stride_coord got (%0d,%0d) required (%0d,%0d)",
                           bus_b.out_row, bus_b.out_col, w.row, w.col);
               end
            end
         end
         if (done_b) seen = 1'b1;
      end
      n_checks++;
      if (!seen || nw != EXP_B || q_b.size() != 0) begin
         n_errors++;
         $display("FAIL stride_count windows=%0d required %0d done=%b", nw, EXP_B, seen);
      end
      q_b.delete();
   endtask

   initial begin
      n_checks = 0; n_errors = 0;
      rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; base_a = '0; base_b = '0;
      bus_a.out_ready = 1'b1; bus_b.out_ready = 1'b1;
      test_reset();
      test_basic();
      test_backpressure();
      test_back_to_back();
      test_busy_start();
      test_reset_mid();
      test_stride();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/sliding_window_ctrl.md
# sliding_window_ctrl

Frame sequencer for the 3x3 sliding-window unit. On a start pulse it:
- clears the window unit;
- streams one feature map from on-chip RAM into it, one pixel per cycle;
- flushes the final window out;
- tags each window the unit produces as legal or row-wrapped, and suppresses the wrapped ones.

It presents only legal windows downstream, with a valid/ready handshake and top-left coordinates. It sits between the feature-map RAM and the convolution MAC array.

## Interface
- IMG_WIDTH, 130, pixels per row; must match the window unit.
- IMG_HEIGHT, 130, rows per frame.
- ADDR_W, 15, RAM address width.
- STRIDE, 1, window stride in rows and columns, 1..4; honoured only with SW_CTRL_STRIDE_EN.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  frame start pulse; ignored while busy.
- base_addr  in  ADDR_W  RAM address of pixel (0,0); sampled with start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse, frame complete.
- mem_rd_en  out  1  RAM read strobe.
- mem_addr  out  ADDR_W  RAM read address.
- mem_rd_data  in  8 signed  read data, valid exactly 1 cycle after mem_rd_en.
- win_rst  out  1  active-high reset to the window unit.
- win_en  out  1  pixel strobe to the window unit.
- win_pixel  out  8 signed  pixel to the window unit.
- out_valid  out  1  a legal window is on the window unit's outputs.
- out_ready  in  1  downstream accepts the window.
- out_row  out  14  top-left row of the presented window.
- out_col  out  14  top-left column of the presented window.

## Operation
**FSM states**
- IDLE: wait for start.
- CLR: win_rst=1 for exactly 1 cycle; reset all counters; latch base_addr.
- STREAM: issue reads mem_addr = base_addr + n, for n = 0..IMG_WIDTH*IMG_HEIGHT-1, in order.
- FLUSH: after the last read has been consumed, one extra win_en with win_pixel=0 and no read. This exposes the window whose bottom-right is the last pixel.
- DRAIN: wait for the final out_valid&&out_ready, pulse done, go to IDLE.

**Pixel FIFO**
- 2-entry pixel FIFO captures mem_rd_data.
- A read is issued only when (FIFO occupancy + reads in flight) < 2, so the FIFO never overflows.
- win_en = FIFO non-empty && (!out_valid || out_ready). It is combinational and pops the FIFO.
- win_pixel = FIFO head.

**Window tagging**
- The window unit's output after the win_en of pixel k has bottom-right pixel k-1, at row r, column c.
- The window is legal iff r>=2 && c>=2, and, with stride, (r-2)%STRIDE==0 && (c-2)%STRIDE==0.
- The modulo is implemented with wrap counters; no dividers.
- out_valid is set on the cycle after a win_en that produced a legal window. It holds until out_ready, and is cleared on accept unless a new legal window arrives on the same edge.
- The window unit's own valid is not used.
- out_row=r-2, out_col=c-2, registered alongside out_valid.
- Windows exposed by the first pixel (k=0) and by row-wrap windows (c<2) never assert out_valid.

**Legal windows per frame**
- Stride 1: (IMG_HEIGHT-2)*(IMG_WIDTH-2).
- Otherwise: ((IMG_HEIGHT-3)/STRIDE+1)*((IMG_WIDTH-3)/STRIDE+1).

## Timing
- Reset values: busy=0, done=0, mem_rd_en=0, mem_addr=0, win_rst=1 (held while rst_n low), win_en=0, out_valid=0, out_row=0, out_col=0; state IDLE; FIFO empty.
- start sampled in IDLE at cycle t:
  - t+1: CLR, win_rst=1, busy=1.
  - t+2: first mem_rd_en.
  - t+3: data returns into the FIFO.
  - t+4: first win_en.
- en to out_valid: 1 cycle.
- Throughput with out_ready held high: 1 pixel per cycle, no bubbles. Frame takes IMG_WIDTH*IMG_HEIGHT+1 win_en cycles.
- out_ready low:
  - win_en is held low;
  - the window unit's outputs, out_row and out_col are frozen;
  - reads continue until the FIFO plus reads in flight reach 2.
- Reads in flight always complete into the FIFO; the RAM is never stalled.
- done pulses on the cycle after the last accept; busy falls on that same cycle. start on the done cycle is ignored; start is accepted from the next cycle.
- rst_n low mid-frame: next edge returns to IDLE with all reset values. The in-flight read is discarded and no done is generated.

## Configuration
- SW_CTRL_STRIDE_EN defined: STRIDE is honoured using row and column phase counters.
- SW_CTRL_STRIDE_EN undefined: stride logic is not compiled; every r>=2, c>=2 window is legal regardless of STRIDE.

## Test plan
- IMG_WIDTH=5, IMG_HEIGHT=4, RAM[i]=i, out_ready=1:
  - exactly 6 out_valid;
  - coordinates (0,0)(0,1)(0,2)(1,0)(1,1)(1,2);
  - first window column-major {0,5,10,1,6,11,2,7,12};
  - 21 win_en;
  - done once.
- Same frame, out_ready toggled 1-0-0-1 repeatedly: identical window sequence; window contents stable while out_valid=1 and out_ready=0; no FIFO overflow; no lost or duplicated pixel.
- Two back-to-back frames with base_addr=0 then 20: win_rst pulses before each; second frame's first window is {20,25,30,21,26,31,22,27,32}.
- SW_CTRL_STRIDE_EN, STRIDE=2, 7x7 frame: 9 windows, rows and cols in {0,2,4}; without the macro: 25 windows.
- rst_n low for 1 cycle mid-STREAM: all outputs at reset values; no done; a new start completes a correct frame.
- start asserted while busy: ignored; base_addr of the running frame unchanged.
